// File: rtl/module_calc.sv
// module_calc: four-function keypad calculator FSM with digit entry, chaining and overflow trap.
// Define MODULE_CALC_SUB_EN to enable key 13 as subtract with signed results.
module module_calc #(
    parameter int RESULT_WIDTH = 14,
    parameter int MAX_DIGITS   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              key_code,
    input  logic                    key_pulse,
    output logic [RESULT_WIDTH-1:0] display_value,
    output logic                    negative,
    output logic                    result_valid,
    output logic                    result_pulse,
    output logic                    overflow
);
`ifdef MODULE_CALC_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif
    localparam int W  = RESULT_WIDTH + 2;
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic signed [W-1:0] MAXV = W'(10 ** MAX_DIGITS - 1);
    localparam logic signed [W-1:0] TEN  = W'(10);
    localparam logic [3:0] K_ADD = 4'd10, K_EQ = 4'd11, K_CLR = 4'd12, K_SUB = 4'd13, K_BS = 4'd14;

    typedef enum logic [2:0] {IDLE, ENTER_A, OP_WAIT, ENTER_B, RESULT, ERROR} state_t;

    state_t                  state_q, state_d;
    logic signed [W-1:0]     a_q, a_d, b_q, b_d;
    logic [CW-1:0]           ca_q, ca_d, cb_q, cb_d;
    logic                    sub_q, sub_d;
    logic [RESULT_WIDTH-1:0] disp_q, disp_d;
    logic                    neg_q, neg_d, valid_q, valid_d, pulse_q, pulse_d, ovf_q, ovf_d;

    logic signed [W-1:0] dig, cur, cur_ext, cur_bs, rhs, acc, mag;
    logic [CW-1:0]       cnt, cnt_ext, cnt_bs;
    logic                entering, is_dig, is_op, do_calc, live;

    assign live     = key_pulse && key_code != K_CLR && state_q != ERROR;
    assign is_dig   = key_code < 4'd10;
    assign is_op    = key_code == K_ADD || (SUB_EN && key_code == K_SUB);
    assign entering = state_q == ENTER_A || state_q == ENTER_B;
    assign dig      = {{(W-4){1'b0}}, key_code};
    assign cur      = state_q == ENTER_A ? a_q : b_q;
    assign cnt      = state_q == ENTER_A ? ca_q : cb_q;
    // Leading zeros leave the operand at 0 and do not consume a digit slot.
    assign cur_ext  = (cur <<< 3) + (cur <<< 1) + dig;
    assign cnt_ext  = cnt + CW'(cur != '0 || key_code != 4'd0);
    assign cur_bs   = cur / TEN;
    assign cnt_bs   = cnt - CW'(cnt != '0);
    assign rhs      = state_q == OP_WAIT ? a_q : b_q;
    assign acc      = sub_q ? a_q - rhs : a_q + rhs;
    assign mag      = acc[W-1] ? -acc : acc;
    assign do_calc  = live && ((is_op && state_q == ENTER_B) ||
                      (key_code == K_EQ && (state_q == ENTER_B || state_q == OP_WAIT)));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ca_d    = ca_q;
        cb_d    = cb_q;
        sub_d   = sub_q;
        disp_d  = disp_q;
        neg_d   = neg_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        pulse_d = 1'b0;
        if (key_pulse && key_code == K_CLR) begin
            state_d = IDLE;
            a_d     = '0;
            b_d     = '0;
            ca_d    = '0;
            cb_d    = '0;
            sub_d   = 1'b0;
            disp_d  = '0;
            neg_d   = 1'b0;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end else if (live && is_dig) begin
            if (state_q == IDLE || state_q == RESULT || state_q == OP_WAIT) begin
                state_d = state_q == OP_WAIT ? ENTER_B : ENTER_A;
                if (state_q == OP_WAIT) begin
                    b_d  = dig;
                    cb_d = CW'(key_code != 4'd0);
                end else begin
                    a_d  = dig;
                    ca_d = CW'(key_code != 4'd0);
                end
                disp_d  = RESULT_WIDTH'(key_code);
                valid_d = 1'b0;
                neg_d   = 1'b0;
            end else if (entering && cnt < CW'(MAX_DIGITS)) begin
                if (state_q == ENTER_A) begin
                    a_d  = cur_ext;
                    ca_d = cnt_ext;
                end else begin
                    b_d  = cur_ext;
                    cb_d = cnt_ext;
                end
                disp_d = cur_ext[RESULT_WIDTH-1:0];
            end
        end else if (live && key_code == K_BS && entering) begin
            if (state_q == ENTER_A) begin
                a_d  = cur_bs;
                ca_d = cnt_bs;
            end else begin
                b_d  = cur_bs;
                cb_d = cnt_bs;
            end
            disp_d = cur_bs[RESULT_WIDTH-1:0];
        end else if (live && is_op && state_q != IDLE) begin
            sub_d   = key_code == K_SUB;
            state_d = OP_WAIT;
        end
        // Result path overrides the operator latch above for chained ENTER_B ops.
        if (do_calc) begin
            pulse_d = 1'b1;
            b_d     = '0;
            cb_d    = '0;
            if (mag > MAXV) begin
                state_d = ERROR;
                ovf_d   = 1'b1;
                disp_d  = '0;
                valid_d = 1'b0;
                neg_d   = 1'b0;
            end else begin
                state_d = key_code == K_EQ ? RESULT : OP_WAIT;
                a_d     = acc;
                disp_d  = mag[RESULT_WIDTH-1:0];
                neg_d   = acc[W-1];
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ca_q    <= '0;
            cb_q    <= '0;
            sub_q   <= 1'b0;
            disp_q  <= '0;
            neg_q   <= 1'b0;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ca_q    <= ca_d;
            cb_q    <= cb_d;
            sub_q   <= sub_d;
            disp_q  <= disp_d;
            neg_q   <= neg_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
            ovf_q   <= ovf_d;
        end
    end

    assign display_value = disp_q;
    assign negative      = SUB_EN & neg_q;
    assign result_valid  = valid_q;
    assign result_pulse  = pulse_q;
    assign overflow      = ovf_q;
endmodule

// File: doc/module_calc.md
MODULE_CALC -- requirements
Module: module_calc

Interface
REQ-001 The module SHALL have parameter RESULT_WIDTH, default 14, giving the bit width of display_value.
REQ-002 The module SHALL have parameter MAX_DIGITS, default 4, giving the digits per operand; MAX_VALUE = 10^MAX_DIGITS-1, and 2^RESULT_WIDTH > MAX_VALUE is required.
REQ-003 clk  input  1  single system clock, rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 key_code  input  4  key: 0-9 digit, 10 ADD, 11 EQUAL, 12 CLEAR, 13 SUB, 14 BACKSPACE, 15 ignored.
REQ-006 key_pulse  input  1  one-cycle strobe qualifying key_code.
REQ-007 display_value  output  RESULT_WIDTH  magnitude to display: operand being entered, or the last result.
REQ-008 negative  output  1  display_value is a negative result.
REQ-009 result_valid  output  1  display_value holds a computed result.
REQ-010 result_pulse  output  1  one-cycle strobe on each new result.
REQ-011 overflow  output  1  sticky error flag; display_value reads 0 while it is set.

Function
REQ-012 States SHALL be IDLE, ENTER_A, OP_WAIT, ENTER_B, RESULT and ERROR.
REQ-013 All outputs SHALL be registered, and every output update SHALL occur on the rising edge following the key_pulse that causes it.
REQ-014 Cycles without key_pulse, and key_code 15, SHALL change nothing, and result_pulse SHALL then be 0.
REQ-015 A digit SHALL behave as follows:
- IDLE/RESULT: operand A = digit, go to ENTER_A, clear result_valid and negative.
- OP_WAIT: operand B = digit, go to ENTER_B.
- ENTER_A/ENTER_B: operand = operand*10 + digit while its digit count < MAX_DIGITS; otherwise the digit is ignored.
REQ-016 A leading 0 SHALL NOT increment the digit count.
REQ-017 BACKSPACE in ENTER_A/ENTER_B SHALL set operand = operand/10 and decrement the digit count; elsewhere it SHALL be ignored.
REQ-018 ADD or SUB SHALL behave as follows:
- ENTER_A: latch the operator, go to OP_WAIT.
- RESULT: the signed result becomes operand A (chaining).
- ENTER_B: compute A op B into A, assert result_pulse, display it with result_valid=1, go to OP_WAIT.
- OP_WAIT: replace the pending operator.
REQ-019 EQUAL in ENTER_B SHALL compute A op B, go to RESULT, and set result_valid=1 and result_pulse=1.
REQ-020 EQUAL in OP_WAIT SHALL use B = A; EQUAL in other states SHALL be ignored.
REQ-021 Arithmetic SHALL be signed at RESULT_WIDTH+2 bits; display_value = |acc| and negative = (acc < 0).
REQ-022 If |acc| > MAX_VALUE, the block SHALL enter ERROR with overflow=1, result_valid=0 and display_value=0, and assert result_pulse.
REQ-023 In ERROR, every key except CLEAR SHALL be ignored.
REQ-024 CLEAR in any state SHALL zero all operands, flags and outputs and go to IDLE, with result_pulse=0.
REQ-025 In ENTER_A/ENTER_B/OP_WAIT without a fresh result, display_value SHALL be the current operand.

Reset
REQ-026 Asserting rst SHALL immediately force IDLE, with display_value=0, negative=0, result_valid=0, result_pulse=0, overflow=0, and all operands, digit counts and the operator cleared.
REQ-027 A computation interrupted by rst SHALL be lost, and no result_pulse SHALL follow deassertion.
REQ-028 The first key_pulse accepted SHALL be on the first rising edge after rst deasserts.

Configuration
REQ-029 With macro MODULE_CALC_SUB_EN defined, key 13 SHALL subtract, and negative results and the negative output SHALL be supported.
REQ-030 Without MODULE_CALC_SUB_EN, key 13 SHALL be ignored like key 15, negative SHALL be tied to 0, and the arithmetic width MAY shrink to RESULT_WIDTH+1 unsigned.

Verification
REQ-031 Keys 1,2,ADD,3,4,EQUAL -> display_value 46, result_valid=1, exactly one result_pulse, one cycle after EQUAL.
REQ-032 Keys 5,ADD,7,ADD,8,EQUAL -> display_value 12 with pulse after the second ADD, then display_value 20 with pulse after EQUAL.
REQ-033 Keys 9,9,9,9,9 (MAX_DIGITS=4) -> display_value 9999; the fifth digit is ignored; BACKSPACE -> 999.
REQ-034 Keys 9999,ADD,1,EQUAL -> overflow=1, display_value=0; a following key 5 is ignored; CLEAR -> all outputs 0, state IDLE.
REQ-035 With MODULE_CALC_SUB_EN: keys 3,SUB,1,0,EQUAL -> display_value 7, negative=1; without the macro, key 13 is ignored and keys 1,0 extend operand A to 310.
REQ-036 rst asserted in ENTER_B (pending 12+3) -> all outputs 0 asynchronously; after release, keys 4,EQUAL produce no result_pulse.
